// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring divider with
// RISC-V special-case handling and a start/busy/done handshake.
module div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  input  logic [TAG_W-1:0] TAG_IN,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [TAG_W-1:0] TAG_OUT
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;
  logic [TAG_W-1:0] tag_q;

  // OP[1] selects remainder, OP[0] selects unsigned
  logic             is_signed_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic             div_zero_c;
  logic             ovf_c;

  always_comb begin
    is_signed_c = ~OP[0];
    a_neg_c     = is_signed_c & DIVIDEND[WIDTH-1];
    b_neg_c     = is_signed_c & DIVISOR[WIDTH-1];
    a_abs_c     = a_neg_c ? -DIVIDEND : DIVIDEND;
    b_abs_c     = b_neg_c ? -DIVISOR : DIVISOR;
    div_zero_c  = (DIVISOR == '0);
    ovf_c       = is_signed_c && (DIVIDEND == MIN_NEG) && (DIVISOR == '1);
  end

  // One restoring step and the sign fix-up, both from registered state
  logic [WIDTH:0]   rem_sh_c;
  logic             ge_c;
  logic [WIDTH:0]   rem_nx_c;
  logic [WIDTH-1:0] quo_nx_c;
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;

  always_comb begin
    rem_sh_c = {rem[WIDTH-1:0], quo[WIDTH-1]};
    ge_c     = (rem_sh_c >= {1'b0, dvsr});
    rem_nx_c = ge_c ? (rem_sh_c - {1'b0, dvsr}) : rem_sh_c;
    quo_nx_c = {quo[WIDTH-2:0], ge_c};
    q_fix_c  = neg_q ? -quo : quo;
    r_fix_c  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      is_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      tag_q   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
      TAG_OUT <= '0;
    end else begin
      DONE <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (START && !FLUSH) begin
            tag_q  <= TAG_IN;
            is_rem <= OP[1];
            cnt    <= '0;
            BUSY   <= 1'b1;
            if (div_zero_c) begin
              RESULT  <= OP[1] ? DIVIDEND : '1;
              TAG_OUT <= TAG_IN;
              state   <= S_DONE;
            end else if (ovf_c) begin
              RESULT  <= OP[1] ? '0 : MIN_NEG;
              TAG_OUT <= TAG_IN;
              state   <= S_DONE;
            end else begin
              rem   <= '0;
              quo   <= a_abs_c;
              dvsr  <= b_abs_c;
              neg_q <= a_neg_c ^ b_neg_c;
              neg_r <= a_neg_c;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (FLUSH) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            rem <= rem_nx_c;
            quo <= quo_nx_c;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (FLUSH) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            RESULT  <= is_rem ? r_fix_c : q_fix_c;
            TAG_OUT <= tag_q;
            state   <= S_DONE;
          end
        end
        default: begin
          // DONE still pulses next cycle even if FLUSH is seen here
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, sign rules, special cases,
// flush, ignored START and mid-operation reset.
module tb_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic [4:0]  TAG_IN;
  logic        FLUSH;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic [4:0]  TAG_OUT;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div_sequencer #(.WIDTH(32), .TAG_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .TAG_IN(TAG_IN), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .TAG_OUT(TAG_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; START is sampled at the following posedge (E0).
  // Returns with time at the negedge after DONE rises (or after the timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit hold,
                        output int lat, output int busy_cyc);
    START = 1'b1; OP = op; DIVIDEND = a; DIVISOR = b; TAG_IN = tag;
    @(negedge CLK);
    if (hold) begin
      OP = DIVU; DIVIDEND = 32'd200; DIVISOR = 32'd9; TAG_IN = 5'd7;
    end else begin
      START = 1'b0;
    end
    lat = 0;
    busy_cyc = 0;
    while (!DONE && lat < 100) begin
      if (BUSY) busy_cyc++;
      @(negedge CLK);
      lat++;
    end
    START = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int lat, busy_cyc, dones;

    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    OP = DIV; DIVIDEND = '0; DIVISOR = '0; TAG_IN = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_tag", 32'(TAG_OUT), 32'd0);

    // Basic unsigned divide: latency, busy length, tag passthrough
    run_op(DIVU, 32'd100, 32'd7, 5'd9, 1'b0, lat, busy_cyc);
    check("divu_result", RESULT, 32'd14);
    check("divu_lat", 32'(lat), 32'd34);
    check("divu_busy", 32'(busy_cyc), 32'd34);
    check("divu_tag", 32'(TAG_OUT), 32'd9);
    @(negedge CLK);
    check("divu_done_1cyc", 32'(DONE), 32'd0);

    vecs.push_back('{"div_m7_2",    DIV,  32'hFFFFFFF9, 32'd2,       32'hFFFFFFFD, 34});
    vecs.push_back('{"rem_m7_2",    REM,  32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 34});
    vecs.push_back('{"rem_7_m2",    REM,  32'd7,        32'hFFFFFFFE, 32'd1,       34});
    vecs.push_back('{"remu_big_2",  REMU, 32'hFFFFFFF9, 32'd2,       32'd1,        34});
    vecs.push_back('{"div_5_0",     DIV,  32'd5,        32'd0,       32'hFFFFFFFF, 1});
    vecs.push_back('{"divu_5_0",    DIVU, 32'd5,        32'd0,       32'hFFFFFFFF, 1});
    vecs.push_back('{"rem_5_0",     REM,  32'd5,        32'd0,       32'd5,        1});
    vecs.push_back('{"remu_min_0",  REMU, 32'h80000000, 32'd0,       32'h80000000, 1});
    vecs.push_back('{"div_ovf",     DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"rem_ovf",     REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,       1});
    vecs.push_back('{"divu_ovfops", DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,       34});
    vecs.push_back('{"divu_back",   DIVU, 32'd100,      32'd7,       32'd14,       34});

    // Issued back to back: each START lands on the edge where DONE falls
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), 1'b0, lat, busy_cyc);
      check({vecs[i].name, "_res"}, RESULT, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_tag"}, 32'(TAG_OUT), 32'(i));
    end
    @(negedge CLK);

    // FLUSH sampled at E11 of DIV 1000/3; previous RESULT is 14
    START = 1'b1; OP = DIV; DIVIDEND = 32'd1000; DIVISOR = 32'd3; TAG_IN = 5'd2;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_busy", 32'(BUSY), 32'd0);
    check("flush_done", 32'(DONE), 32'd0);
    check("flush_result", RESULT, 32'd14);
    // Immediate restart; a leaked DONE from the flushed op would cut latency short
    run_op(REMU, 32'd1000, 32'd3, 5'd4, 1'b0, lat, busy_cyc);
    check("post_flush_res", RESULT, 32'd1);
    check("post_flush_lat", 32'(lat), 32'd34);
    check("post_flush_tag", 32'(TAG_OUT), 32'd4);
    @(negedge CLK);

    // START held with changed operands: only the original op completes
    run_op(DIVU, 32'd100, 32'd7, 5'd3, 1'b1, lat, busy_cyc);
    check("hold_res", RESULT, 32'd14);
    check("hold_lat", 32'(lat), 32'd34);
    check("hold_tag", 32'(TAG_OUT), 32'd3);
    @(negedge CLK);

    // RESET at cycle 20 of DIV 1000/3
    START = 1'b1; OP = DIV; DIVIDEND = 32'd1000; DIVISOR = 32'd3; TAG_IN = 5'd6;
    @(negedge CLK);
    START = 1'b0;
    repeat (19) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    check("mid_rst_result", RESULT, 32'd0);
    check("mid_rst_tag", 32'(TAG_OUT), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("mid_rst_no_done", 32'(dones), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
